parity_frame_gen: RTL and testbench
===================================

// Module: parity_frame_gen
// PURPOSE
//  Streaming frame-parity generator/checker. Parametrised successor of the 4-bit combinational parity encoder.
//  - Accepts WIDTH-bit beats over a valid/ready stream.
//  - Accumulates even or odd parity across a multi-beat frame delimited by s_last.
//  - Presents one registered result per frame: parity bit, beat count and check error.
//  - Sits between a data source and a framer/link encoder.
// PARAMETERS
//  WIDTH   8  data bits per beat (>=1)
//  CNT_W   8  beat-counter width; the count saturates at 2^CNT_W-1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  odd_mode   in   1        1 = odd parity, 0 = even; sampled on a frame's first accepted beat
//  s_valid    in   1        input beat valid
//  s_ready    out  1        input beat ready
//  s_data     in   WIDTH    input beat data
//  s_last     in   1        final beat of the frame
//  s_par_exp  in   1        expected parity; sampled with the last beat (check mode)
//  m_valid    out  1        frame result valid
//  m_ready    in   1        frame result accepted
//  m_parity   out  1        frame parity bit
//  m_beats    out  CNT_W    beats in the frame (saturated)
//  m_sat      out  1        beat count saturated
//  m_err      out  1        m_parity != s_par_exp
// BEHAVIOUR
//  - Beat transfer: s_valid & s_ready at a rising clk edge.
//  - Result transfer: m_valid & m_ready at a rising clk edge.
//  - s_ready = ~m_valid | m_ready (combinational).
//    - No stall while the output slot is empty or is being drained.
//  - States:
//    - IDLE:  no frame open. A beat with s_last=0 -> ACCUM. A beat with s_last=1 -> single-beat frame, stay IDLE.
//    - ACCUM: frame open. A beat with s_last=1 -> IDLE.
//  - Accumulator:
//    - acc <= (first beat ? mode_bit : acc) ^ (^s_data)
//    - mode_bit = odd_mode on the first beat; it is latched for the rest of the frame.
//    - odd_mode changes mid-frame are ignored.
//  - Counter:
//    - cnt <= first beat ? 1 : (cnt == max ? max : cnt + 1)
//    - sat <= set when an increment is blocked at max; cleared on the first beat.
//  - Last-beat acceptance at edge N:
//    - m_parity, m_beats, m_sat and m_err load final values; m_valid=1 from edge N.
//    - Latency: 1 cycle from the last beat to the result.
//  - m_err = final parity XOR s_par_exp sampled on the last beat.
//  - Output hold:
//    - m_* stays stable while m_valid & ~m_ready.
//    - s_ready=0 in that condition, so no beat is lost or accumulated.
//  - Simultaneous events:
//    - Result drained and new last beat accepted on the same edge -> new result loads; m_valid stays 1.
//    - Result drained, no new last beat -> m_valid <= 0.
//  - Back-to-back single-beat frames sustain one frame per cycle when m_ready=1.
//  - Reset (any time, incl. mid-frame):
//    - state=IDLE; acc, cnt and sat = 0.
//    - m_valid, m_parity, m_err, m_sat = 0; m_beats = 0.
//    - A partial frame is discarded; there is no result for it.
//  - WIDTH=1 is legal: per-beat parity is the data bit.
// TESTING
//  - T1: WIDTH=8, even; one beat 8'hA5, last, s_par_exp=0 -> next cycle m_valid=1, m_parity=0, m_beats=1, m_err=0.
//  - T2: odd; beats 8'h01, 8'h03, 8'h07 (last), s_par_exp=0 -> m_parity=1, m_beats=3, m_err=1.
//  - T3: hold m_ready=0 after a result; offer a new frame -> s_ready=0, m_* unchanged for 5 cycles; release -> result drains, next frame proceeds.
//  - T4: CNT_W=2, 5-beat frame of 8'hFF, even -> m_parity=0, m_beats=3, m_sat=1.
//  - T5: rst_n low for 1 cycle after beat 2 of a 4-beat frame -> all outputs 0; following 1-beat frame 8'h01 even -> m_parity=1, m_beats=1.
//  - T6: continuous single-beat frames with m_ready=1 and random data/mode -> one result per cycle, each checked against a reference XOR model.

Source files
------------

// File: rtl/parity_frame_gen_if.sv
// parity_frame_gen_if: beat stream in, frame result out, plus per-frame side inputs
interface parity_frame_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             odd_mode;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_par_exp;
  logic             m_valid;
  logic             m_ready;
  logic             m_parity;
  logic [CNT_W-1:0] m_beats;
  logic             m_sat;
  logic             m_err;
  modport master (
    output odd_mode, s_valid, s_data, s_last, s_par_exp, m_ready,
    input  s_ready, m_valid, m_parity, m_beats, m_sat, m_err
  );
  modport slave (
    input  odd_mode, s_valid, s_data, s_last, s_par_exp, m_ready,
    output s_ready, m_valid, m_parity, m_beats, m_sat, m_err
  );
endinterface

// File: rtl/parity_frame_gen.sv
// parity_frame_gen: accumulates even/odd parity and a saturating beat count per frame, one registered result per frame
module parity_frame_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  parity_frame_gen_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t           r_state, w_state_nxt;
  logic             r_acc, r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_m_valid, r_m_parity, r_m_sat, r_m_err;
  logic [CNT_W-1:0] r_m_beats;
  logic             w_fire, w_first, w_acc, w_sat;
  logic [CNT_W-1:0] w_cnt;
  assign bus.s_ready  = ~r_m_valid | bus.m_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_parity = r_m_parity;
  assign bus.m_beats  = r_m_beats;
  assign bus.m_sat    = r_m_sat;
  assign bus.m_err    = r_m_err;
  // next-state and the running parity/count including the beat on offer
  always_comb begin
    w_fire      = bus.s_valid & bus.s_ready;
    w_first     = (r_state == IDLE);
    w_acc       = (w_first ? bus.odd_mode : r_acc) ^ (^bus.s_data);
    w_cnt       = w_first ? CNT_W'(1) : (r_cnt == CNT_MAX ? CNT_MAX : r_cnt + CNT_W'(1));
    w_sat       = w_first ? 1'b0 : (r_sat | (r_cnt == CNT_MAX));
    w_state_nxt = r_state;
    if (w_fire) w_state_nxt = bus.s_last ? IDLE : ACCUM;
  end
  // frame state register and accumulators; a reset drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_acc <= w_acc;
        r_cnt <= w_cnt;
        r_sat <= w_sat;
      end
    end
  end
  // result slot: loads on the last beat, holds until drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_parity <= 1'b0;
      r_m_beats  <= '0;
      r_m_sat    <= 1'b0;
      r_m_err    <= 1'b0;
    end else if (w_fire && bus.s_last) begin
      r_m_valid  <= 1'b1;
      r_m_parity <= w_acc;
      r_m_beats  <= w_cnt;
      r_m_sat    <= w_sat;
      r_m_err    <= w_acc ^ bus.s_par_exp;
    end else if (bus.m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_parity_frame_gen.sv
// tb_parity_frame_gen: directed frames checked against a frame-level parity model on two counter widths
module tb_parity_frame_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic odd_mode = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_par_exp = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = 8'h00;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  parity_frame_gen_if #(.WIDTH(8), .CNT_W(8)) ifa ();
  parity_frame_gen_if #(.WIDTH(8), .CNT_W(2)) ifb ();
  assign ifa.odd_mode = odd_mode;  assign ifb.odd_mode = odd_mode;
  assign ifa.s_valid = s_valid;    assign ifb.s_valid = s_valid;
  assign ifa.s_data = s_data;      assign ifb.s_data = s_data;
  assign ifa.s_last = s_last;      assign ifb.s_last = s_last;
  assign ifa.s_par_exp = s_par_exp; assign ifb.s_par_exp = s_par_exp;
  assign ifa.m_ready = m_ready;    assign ifb.m_ready = m_ready;

  parity_frame_gen #(.WIDTH(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  parity_frame_gen #(.WIDTH(8), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // frame-level model: total ones across the frame plus the mode decide parity
  typedef struct {logic par; int n; logic err;} res_t;
  res_t q[$];
  bit   open_f = 0;
  logic cur_mode;
  int   cur_ones, cur_n;
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      open_f = 0;
    end else begin
      bit rdy;
      rdy = (q.size() == 0) || m_ready;
      if (m_ready && q.size() != 0) void'(q.pop_front());
      if (s_valid && rdy) begin
        if (!open_f) begin
          cur_mode = odd_mode;
          cur_ones = 0;
          cur_n = 0;
        end
        cur_ones += $countones(s_data);
        cur_n++;
        open_f = !s_last;
        if (s_last) begin
          res_t r;
          r.par = cur_mode ^ cur_ones[0];
          r.n   = cur_n;
          r.err = r.par ^ s_par_exp;
          q.push_back(r);
        end
      end
    end
  end

  task automatic cmp_dut(input string t, input int mx, input logic v, input logic rdy,
                         input logic p, input int b, input logic s, input logic e);
    chk({t, ".m_valid"}, v, q.size() != 0);
    chk({t, ".s_ready"}, rdy, (q.size() == 0) || m_ready);
    if (q.size() != 0) begin
      chk({t, ".m_parity"}, p, q[0].par);
      chk({t, ".m_beats"}, b, q[0].n > mx ? mx : q[0].n);
      chk({t, ".m_sat"}, s, q[0].n > mx);
      chk({t, ".m_err"}, e, q[0].err);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("A", 255, ifa.m_valid, ifa.s_ready, ifa.m_parity, int'(ifa.m_beats), ifa.m_sat, ifa.m_err);
      cmp_dut("B", 3, ifb.m_valid, ifb.s_ready, ifb.m_parity, int'(ifb.m_beats), ifb.m_sat, ifb.m_err);
    end
  end

  // offers one beat from posedge+1 and returns at posedge+1 after it is taken
  task automatic beat(input logic [7:0] d, input logic last, input logic mode,
                      input logic pexp, output int stalls);
    s_valid = 1'b1; s_data = d; s_last = last; odd_mode = mode; s_par_exp = pexp;
    stalls = 0;
    @(negedge clk);
    while (!ifa.s_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!ifa.s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: s_ready stuck at 0, required 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic reset_outputs_zero(input string t);
    chk({t, ".A.m_valid"}, ifa.m_valid, 0);
    chk({t, ".A.m_parity"}, ifa.m_parity, 0);
    chk({t, ".A.m_beats"}, int'(ifa.m_beats), 0);
    chk({t, ".A.m_sat"}, ifa.m_sat, 0);
    chk({t, ".A.m_err"}, ifa.m_err, 0);
    chk({t, ".B.m_valid"}, ifb.m_valid, 0);
  endtask

  initial begin
    int st, tot;
    logic [7:0] d;
    @(negedge clk);
    reset_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // T1
    beat(8'hA5, 1, 0, 0, st);
    @(negedge clk);
    chk("T1.m_valid", ifa.m_valid, 1);
    chk("T1.m_parity", ifa.m_parity, 0);
    chk("T1.m_beats", int'(ifa.m_beats), 1);
    chk("T1.m_err", ifa.m_err, 0);
    @(posedge clk); #1;
    // T2
    beat(8'h01, 0, 1, 0, st);
    beat(8'h03, 0, 0, 0, st);
    beat(8'h07, 1, 0, 0, st);
    @(negedge clk);
    chk("T2.m_parity", ifa.m_parity, 1);
    chk("T2.m_beats", int'(ifa.m_beats), 3);
    chk("T2.m_err", ifa.m_err, 1);
    @(posedge clk); #1;
    // T3
    m_ready = 1'b0;
    beat(8'h0F, 1, 1, 1, st);
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b1; odd_mode = 1'b0; s_par_exp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("T3.hold.s_ready", ifa.s_ready, 0);
      chk("T3.hold.m_valid", ifa.m_valid, 1);
      chk("T3.hold.m_parity", ifa.m_parity, 1);
      chk("T3.hold.m_err", ifa.m_err, 0);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("T3.release.s_ready", ifa.s_ready, 1);
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    chk("T3.next.m_valid", ifa.m_valid, 1);
    chk("T3.next.m_parity", ifa.m_parity, 1);
    chk("T3.next.m_err", ifa.m_err, 1);
    @(posedge clk); #1;
    // T4
    for (int i = 0; i < 5; i++) beat(8'hFF, i == 4, 0, 0, st);
    @(negedge clk);
    chk("T4.B.m_parity", ifb.m_parity, 0);
    chk("T4.B.m_beats", int'(ifb.m_beats), 3);
    chk("T4.B.m_sat", ifb.m_sat, 1);
    chk("T4.A.m_beats", int'(ifa.m_beats), 5);
    chk("T4.A.m_sat", ifa.m_sat, 0);
    @(posedge clk); #1;
    // T5
    beat(8'h11, 0, 1, 0, st);
    beat(8'h22, 0, 1, 0, st);
    rst_n = 1'b0;
    @(negedge clk);
    reset_outputs_zero("T5.reset");
    @(posedge clk); #1 rst_n = 1'b1;
    beat(8'h01, 1, 0, 0, st);
    @(negedge clk);
    chk("T5.m_valid", ifa.m_valid, 1);
    chk("T5.m_parity", ifa.m_parity, 1);
    chk("T5.m_beats", int'(ifa.m_beats), 1);
    @(posedge clk); #1;
    // T6
    tot = 0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      beat(d, 1, 1'($urandom), 1'($urandom), st);
      tot += st;
    end
    chk("T6.stall_cycles", tot, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end.m_valid", ifa.m_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
